padring_ctrl: RTL and testbench

//  Sequencer for the GPIO pad ring: owns per-pad output-enable/data to PADRING and decides who drives the pads.

---
 rtl/padring_pkg.sv | 17 +
 rtl/padring_ctrl_if.sv | 13 +
 rtl/padring_tm_sync.sv | 49 ++++
 rtl/padring_ctrl.sv | 162 ++++++++++++++++
 tb/tb_padring_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/padring_pkg.sv
// rtl/padring_pkg.sv - shared types and sizing helpers for the pad ring sequencer
package padring_pkg;

  typedef enum logic [1:0] {
    ST_FUNC  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TEST  = 2'd2
  } state_e;

  localparam int GPIO_WIDTH_DEF = 15;

  // Width of a counter that must hold values 0..n
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/padring_ctrl_if.sv
// rtl/padring_ctrl_if.sv - direction-config handshake between functional core and sequencer
interface padring_ctrl_if
  import padring_pkg::*;
#(
  parameter int W = GPIO_WIDTH_DEF
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_oe;

  modport master (output cfg_valid, output cfg_oe, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_oe, output cfg_ready);
endinterface

// File: rtl/padring_tm_sync.sv
// rtl/padring_tm_sync.sv - pad_tm synchronizer and debounce, produces a stable mode request
module padring_tm_sync
  import padring_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TM_DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_tm_in,
  output logic tm_stable
);
  localparam int DW = cnt_w(TM_DEBOUNCE);
  localparam logic [DW-1:0] DEB_LAST = DW'(TM_DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic                   tm_stable_q, tm_stable_d;
  logic                   tm_sync;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pad_tm_in};
    tm_sync     = sync_q[SYNC_STAGES-1];
    cnt_d       = '0;
    tm_stable_d = tm_stable_q;
    // Any cycle agreeing with the current mode restarts the debounce window
    if (tm_sync != tm_stable_q) begin
      if (cnt_q == DEB_LAST) begin
        tm_stable_d = tm_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      tm_stable_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      tm_stable_q <= tm_stable_d;
    end
  end

  assign tm_stable = tm_stable_q;
endmodule

// File: rtl/padring_ctrl.sv
// rtl/padring_ctrl.sv - pad ownership FSM with turnaround-separated direction changes
module padring_ctrl
  import padring_pkg::*;
#(
  parameter int GPIO_WIDTH  = GPIO_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TM_DEBOUNCE = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pad_tm_in,
  padring_ctrl_if.slave         cfg,
  input  logic [GPIO_WIDTH-1:0] func_out,
  input  logic [GPIO_WIDTH-1:0] test_oe,
  input  logic [GPIO_WIDTH-1:0] test_out,
  output logic [GPIO_WIDTH-1:0] pad_oe,
  output logic [GPIO_WIDTH-1:0] pad_out,
  output logic                  tmode,
  output logic                  busy
);
  localparam int TW = cnt_w(TURN_CYCLES);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

  state_e                state_q, state_d, target_q, target_d, want;
  logic [GPIO_WIDTH-1:0] oe_reg_q, oe_reg_d, pad_oe_q, pad_oe_d, pad_out_q, pad_out_d;
  logic [TW-1:0]         turn_cnt_q, turn_cnt_d;
  logic                  turn_pend_q, turn_pend_d;
  logic                  cfg_ready_q, cfg_ready_d, busy_q, busy_d, tmode_q, tmode_d;
  logic                  tm_stable, accept;
  logic [GPIO_WIDTH-1:0] rise;

  padring_tm_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .TM_DEBOUNCE (TM_DEBOUNCE)
  ) u_tm (
    .clk       (clk),
    .rst       (rst),
    .pad_tm_in (pad_tm_in),
    .tm_stable (tm_stable)
  );

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    oe_reg_d    = oe_reg_q;
    pad_oe_d    = pad_oe_q;
    turn_cnt_d  = turn_cnt_q;
    turn_pend_d = turn_pend_q;
    cfg_ready_d = cfg_ready_q;
    busy_d      = busy_q;
    accept      = cfg.cfg_valid & cfg_ready_q;
    rise        = cfg.cfg_oe & ~oe_reg_q;
    want        = tm_stable ? ST_TEST : ST_FUNC;
    case (state_q)
      ST_FUNC: begin
        if (accept) oe_reg_d = cfg.cfg_oe;
        if (tm_stable) begin
          state_d     = ST_DRAIN;
          target_d    = ST_TEST;
          turn_cnt_d  = TURN_LOAD;
          turn_pend_d = 1'b0;
          pad_oe_d    = '0;
          cfg_ready_d = 1'b0;
          busy_d      = 1'b1;
        end else if (accept && (|rise)) begin
          // Release dropped drivers now; newly enabled ones wait out the turnaround
          turn_pend_d = 1'b1;
          turn_cnt_d  = TURN_LOAD;
          pad_oe_d    = pad_oe_q & cfg.cfg_oe;
          cfg_ready_d = 1'b0;
          busy_d      = 1'b1;
        end else if (accept) begin
          pad_oe_d = cfg.cfg_oe;
        end else if (turn_pend_q) begin
          if (turn_cnt_q == '0) begin
            turn_pend_d = 1'b0;
            pad_oe_d    = oe_reg_q;
            cfg_ready_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            turn_cnt_d = turn_cnt_q - 1'b1;
          end
        end else begin
          pad_oe_d    = oe_reg_q;
          cfg_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        pad_oe_d    = '0;
        cfg_ready_d = 1'b0;
        busy_d      = 1'b1;
        if (want != target_q) begin
          target_d   = want;
          turn_cnt_d = TURN_LOAD;
        end else if (turn_cnt_q == '0) begin
          state_d = target_q;
          busy_d  = 1'b0;
          if (target_q == ST_FUNC) begin
            pad_oe_d    = oe_reg_q;
            cfg_ready_d = 1'b1;
          end else begin
            pad_oe_d = test_oe;
          end
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      ST_TEST: begin
        pad_oe_d    = test_oe;
        cfg_ready_d = 1'b0;
        busy_d      = 1'b0;
        if (!tm_stable) begin
          state_d    = ST_DRAIN;
          target_d   = ST_FUNC;
          turn_cnt_d = TURN_LOAD;
          pad_oe_d   = '0;
          busy_d     = 1'b1;
        end
      end
      default: begin
        state_d  = ST_FUNC;
        pad_oe_d = '0;
      end
    endcase
    tmode_d   = (state_d == ST_TEST);
    pad_out_d = (tmode_d ? test_out : func_out) & pad_oe_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FUNC;
      target_q    <= ST_FUNC;
      oe_reg_q    <= '0;
      pad_oe_q    <= '0;
      pad_out_q   <= '0;
      turn_cnt_q  <= '0;
      turn_pend_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      tmode_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      oe_reg_q    <= oe_reg_d;
      pad_oe_q    <= pad_oe_d;
      pad_out_q   <= pad_out_d;
      turn_cnt_q  <= turn_cnt_d;
      turn_pend_q <= turn_pend_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      tmode_q     <= tmode_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign pad_oe        = pad_oe_q;
  assign pad_out       = pad_out_q;
  assign tmode         = tmode_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_padring_ctrl.sv
// tb/tb_padring_ctrl.sv - scoreboard bench for padring_ctrl with cycle-tagged expectations
module tb_padring_ctrl;
  import padring_pkg::*;

  localparam int W = 15;

  typedef struct {
    int          cyc;
    logic [W-1:0] oe;
    logic [W-1:0] out;
    logic        tm;
    logic        bz;
    logic        rdy;
    string       nm;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         pad_tm_in;
  logic [W-1:0] func_out, test_oe, test_out, pad_oe, pad_out;
  logic         tmode, busy;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           done = 1'b0;
  exp_t         q[$];

  padring_ctrl_if #(.W(W)) cfg_bus ();

  padring_ctrl #(
    .GPIO_WIDTH  (W),
    .SYNC_STAGES (2),
    .TM_DEBOUNCE (4),
    .TURN_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pad_tm_in (pad_tm_in),
    .cfg       (cfg_bus.slave),
    .func_out  (func_out),
    .test_oe   (test_oe),
    .test_out  (test_out),
    .pad_oe    (pad_oe),
    .pad_out   (pad_out),
    .tmode     (tmode),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int d, input string nm, input logic [W-1:0] oe, input logic [W-1:0] out,
                      input logic tm, input logic bz, input logic rdy);
    exp_t e;
    int   i;
    e.cyc = cyc + d; e.oe = oe; e.out = out; e.tm = tm; e.bz = bz; e.rdy = rdy; e.nm = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  task automatic cmp(input string nm, input int c, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  // Monitor: pops every expectation tagged for the current cycle and compares it
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s missed check at cycle %0d", e.nm, e.cyc);
      end else begin
        cmp({e.nm, ".pad_oe"},    cyc, pad_oe, e.oe);
        cmp({e.nm, ".pad_out"},   cyc, pad_out, e.out);
        cmp({e.nm, ".tmode"},     cyc, W'(tmode), W'(e.tm));
        cmp({e.nm, ".busy"},      cyc, W'(busy), W'(e.bz));
        cmp({e.nm, ".cfg_ready"}, cyc, W'(cfg_bus.cfg_ready), W'(e.rdy));
      end
    end
    if (done) begin
      cmp("queue_drained", cyc, W'(q.size()), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic send_cfg(input logic [W-1:0] oe);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_oe    = oe;
    tick(1);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pad_tm_in = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_oe = '0;
    func_out = 15'h7FFF; test_oe = 15'h7FFF; test_out = 15'h5555;
    tick(3);
    push(0, "reset", 15'h0, 15'h0, 0, 0, 0);
    rst = 1'b0;
    push(1, "post_reset", 15'h0, 15'h0, 0, 0, 1);
    tick(2);

    // 1: enabling drivers goes through a two-cycle released turnaround
    push(1, "t1_turn1", 15'h0, 15'h0, 0, 1, 0);
    push(2, "t1_turn2", 15'h0, 15'h0, 0, 1, 0);
    push(3, "t1_apply", 15'h00FF, 15'h00FF, 0, 0, 1);
    send_cfg(15'h00FF);
    tick(4);

    // 2: only releasing drivers applies next cycle with no turnaround
    push(1, "t2_apply", 15'h000F, 15'h000F, 0, 0, 1);
    push(2, "t2_hold", 15'h000F, 15'h000F, 0, 0, 1);
    send_cfg(15'h000F);
    tick(3);

    // 3a: a 3-cycle pulse on pad_tm is filtered out
    for (int d = 1; d <= 12; d++) push(d, "t3_pulse", 15'h000F, 15'h000F, 0, 0, 1);
    pad_tm_in = 1'b1;
    tick(3);
    pad_tm_in = 1'b0;
    tick(10);

    // 3b: held pad_tm -> DRAIN at +7, TEST at +9
    for (int d = 1; d <= 6; d++) push(d, "t3_func", 15'h000F, 15'h000F, 0, 0, 1);
    push(7, "t3_drain", 15'h0, 15'h0, 0, 1, 0);
    push(8, "t3_drain", 15'h0, 15'h0, 0, 1, 0);
    push(9, "t3_test", 15'h7FFF, 15'h5555, 1, 0, 0);
    push(10, "t3_test", 15'h7FFF, 15'h5555, 1, 0, 0);
    pad_tm_in = 1'b1;
    tick(11);

    // 4: leaving TEST drains then restores the functional enables
    for (int d = 1; d <= 6; d++) push(d, "t4_test", 15'h7FFF, 15'h5555, 1, 0, 0);
    push(7, "t4_drain", 15'h0, 15'h0, 0, 1, 0);
    push(8, "t4_drain", 15'h0, 15'h0, 0, 1, 0);
    push(9, "t4_func", 15'h000F, 15'h000F, 0, 0, 1);
    push(10, "t4_func", 15'h000F, 15'h000F, 0, 0, 1);
    pad_tm_in = 1'b0;
    tick(11);

    // 5: cfg accepted in the same cycle the mode request rises
    push(6, "t5_accept", 15'h000F, 15'h000F, 0, 0, 1);
    push(7, "t5_drain", 15'h0, 15'h0, 0, 1, 0);
    push(8, "t5_drain", 15'h0, 15'h0, 0, 1, 0);
    push(9, "t5_test", 15'h7FFF, 15'h5555, 1, 0, 0);
    pad_tm_in = 1'b1;
    tick(6);
    send_cfg(15'h00F0);
    tick(4);
    push(7, "t5_drain_back", 15'h0, 15'h0, 0, 1, 0);
    push(9, "t5_func_new", 15'h00F0, 15'h00F0, 0, 0, 1);
    push(10, "t5_func_new", 15'h00F0, 15'h00F0, 0, 0, 1);
    pad_tm_in = 1'b0;
    tick(11);

    // 6a: reset while draining
    push(7, "t6_drain", 15'h0, 15'h0, 0, 1, 0);
    pad_tm_in = 1'b1;
    tick(7);
    rst = 1'b1;
    pad_tm_in = 1'b0;
    push(1, "t6_rst_drain", 15'h0, 15'h0, 0, 0, 0);
    tick(1);
    rst = 1'b0;
    push(1, "t6_after_rst", 15'h0, 15'h0, 0, 0, 1);
    push(8, "t6_stay_func", 15'h0, 15'h0, 0, 0, 1);
    tick(9);

    // 6b: reset mid-turnaround aborts the pending enables
    send_cfg(15'h00FF);
    push(0, "t6_turn", 15'h0, 15'h0, 0, 1, 0);
    rst = 1'b1;
    push(1, "t6_rst_turn", 15'h0, 15'h0, 0, 0, 0);
    tick(1);
    rst = 1'b0;
    push(1, "t6_idle", 15'h0, 15'h0, 0, 0, 1);
    push(3, "t6_no_apply", 15'h0, 15'h0, 0, 0, 1);
    tick(5);
    done = 1'b1;
  end
endmodule
